// File: rtl/puf_pkg.sv
// Shared state encoding and default timing constants for the arbiter-PUF race launcher.
package puf_pkg;

    localparam int CHAL_W_DEF      = 64;
    localparam int SETTLE_CYC_DEF  = 4;
    localparam int CAPTURE_CYC_DEF = 4;
    localparam int VOTES_DEF       = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        FIRE    = 3'd2,
        SAMPLE  = 3'd3,
        RECOVER = 3'd4,
        DONE    = 3'd5
    } puf_state_e;

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchroniser bringing the asynchronous arbiter capture result into the clk domain.
module puf_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture chain; the first stage may go metastable and settles before the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/puf_race_launcher.sv
// Applies a challenge to the PUF delay lines, fires VOTES races and returns a majority-voted response.
module puf_race_launcher
    import puf_pkg::*;
#(
    parameter  int CHAL_W      = CHAL_W_DEF,
    parameter  int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter  int CAPTURE_CYC = CAPTURE_CYC_DEF,
    parameter  int VOTES       = VOTES_DEF,
    localparam int CNT_W       = $clog2(VOTES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chal_valid,
    output logic              chal_ready,
    input  logic [CHAL_W-1:0] chal_data,
    output logic [CHAL_W-1:0] chal_out,
    output logic              launch,
    input  logic              arb_in,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_bit,
    output logic [CNT_W-1:0]  resp_ones,
    output logic              resp_stable
);

    localparam int CYC_MAX = (SETTLE_CYC > CAPTURE_CYC) ? SETTLE_CYC : CAPTURE_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0] SETTLE_LAST  = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] CAPTURE_LAST = CYC_W'(CAPTURE_CYC - 1);
    localparam logic [CNT_W-1:0] VOTES_C      = CNT_W'(VOTES);
    localparam logic [CNT_W-1:0] HALF_C       = CNT_W'(VOTES / 2);

    puf_state_e       state_r;
    logic [CYC_W-1:0] cyc_r;
    logic [CNT_W-1:0] vote_r;
    logic [CNT_W-1:0] ones_r;
    logic             arb_sync_s;

    puf_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (arb_in),
        .q     (arb_sync_s)
    );

    assign chal_ready = (state_r == IDLE);

    // Race sequencer: launch is set on entry to FIRE and cleared on leaving SAMPLE, so it comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cyc_r       <= {CYC_W{1'b0}};
            vote_r      <= {CNT_W{1'b0}};
            ones_r      <= {CNT_W{1'b0}};
            chal_out    <= {CHAL_W{1'b0}};
            launch      <= 1'b0;
            resp_valid  <= 1'b0;
            resp_bit    <= 1'b0;
            resp_ones   <= {CNT_W{1'b0}};
            resp_stable <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (chal_valid) begin
                        chal_out <= chal_data;
                        ones_r   <= {CNT_W{1'b0}};
                        vote_r   <= {CNT_W{1'b0}};
                        cyc_r    <= {CYC_W{1'b0}};
                        state_r  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cyc_r == SETTLE_LAST) begin
                        cyc_r   <= {CYC_W{1'b0}};
                        launch  <= 1'b1;
                        state_r <= FIRE;
                    end else begin
                        cyc_r <= cyc_r + CYC_W'(1);
                    end
                end
                FIRE: begin
                    if (cyc_r == CAPTURE_LAST) begin
                        cyc_r   <= {CYC_W{1'b0}};
                        state_r <= SAMPLE;
                    end else begin
                        cyc_r <= cyc_r + CYC_W'(1);
                    end
                end
                SAMPLE: begin
                    ones_r  <= ones_r + CNT_W'(arb_sync_s);
                    vote_r  <= vote_r + CNT_W'(1);
                    launch  <= 1'b0;
                    state_r <= RECOVER;
                end
                RECOVER: begin
                    if (cyc_r == SETTLE_LAST) begin
                        cyc_r <= {CYC_W{1'b0}};
                        if (vote_r == VOTES_C) begin
                            resp_valid  <= 1'b1;
                            resp_bit    <= (ones_r > HALF_C);
                            resp_ones   <= ones_r;
                            resp_stable <= (ones_r == {CNT_W{1'b0}}) || (ones_r == VOTES_C);
                            state_r     <= DONE;
                        end else begin
                            launch  <= 1'b1;
                            state_r <= FIRE;
                        end
                    end else begin
                        cyc_r <= cyc_r + CYC_W'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    launch     <= 1'b0;
                    resp_valid <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_race_launcher.sv
// Directed and randomized checks of the race launcher against a vote-counting reference model.
module tb_puf_race_launcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        chal_valid;
    logic        chal_ready;
    logic [63:0] chal_data;
    logic [63:0] chal_out;
    logic        launch;
    logic        arb_in;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_bit;
    logic [2:0]  resp_ones;
    logic        resp_stable;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [4:0] race_bits = 5'b00000;
    logic [2:0] race_idx  = 3'd0;
    logic       launch_prev = 1'b0;
    int         lo_run = 0;
    int         hi_run = 0;
    int         lo_q[$];
    int         hi_q[$];

    puf_race_launcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chal_valid  (chal_valid),
        .chal_ready  (chal_ready),
        .chal_data   (chal_data),
        .chal_out    (chal_out),
        .launch      (launch),
        .arb_in      (arb_in),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_bit    (resp_bit),
        .resp_ones   (resp_ones),
        .resp_stable (resp_stable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Arbiter stand-in plus launch waveform recorder: each new launch pulse gets the next race outcome.
    always @(negedge clk) begin
        if (launch) begin
            if (!launch_prev) begin
                lo_q.push_back(lo_run);
                hi_run = 1;
                arb_in = (race_idx < 3'd5) ? race_bits[race_idx] : 1'b0;
                race_idx = race_idx + 3'd1;
            end else begin
                hi_run++;
            end
        end else begin
            if (launch_prev) begin
                hi_q.push_back(hi_run);
                lo_run = 1;
            end else begin
                lo_run++;
            end
        end
        launch_prev = launch;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full evaluation: accept, race with chal_valid noise, check response, optional backpressure, handshake.
    task automatic do_race(input string tag, input logic [63:0] ch, input logic [4:0] bits, input int hold);
        int t_acc;
        int lat;
        int ones_exp;
        int bad;
        logic [63:0] snap;
        race_bits = bits;
        race_idx  = 3'd0;
        check({tag, "_ready"}, 64'(chal_ready), 64'd1);
        chal_valid = 1'b1;
        chal_data  = ch;
        t_acc = cyc;
        @(posedge clk); #1;
        chal_valid = 1'b0;
        chal_data  = {$urandom, $urandom};
        lo_q.delete();
        hi_q.delete();
        lo_run = 0;
        check({tag, "_chal_out"}, chal_out, ch);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = cyc - t_acc;
                break;
            end
            chal_valid = 1'($urandom_range(0, 1));
            chal_data  = {$urandom, $urandom};
        end
        chal_valid = 1'b0;
        ones_exp = $countones(bits);
        check({tag, "_latency"}, 64'(lat), 64'd50);
        check({tag, "_chal_hold"}, chal_out, ch);
        check({tag, "_bit"}, 64'(resp_bit), 64'(ones_exp > 2));
        check({tag, "_ones"}, 64'(resp_ones), 64'(ones_exp));
        check({tag, "_stable"}, 64'(resp_stable), 64'(ones_exp == 0 || ones_exp == 5));
        check({tag, "_pulses"}, 64'(hi_q.size()), 64'd5);
        for (int i = 0; i < hi_q.size(); i++) check({tag, "_hi_len"}, 64'(hi_q[i]), 64'd5);
        for (int i = 0; i < lo_q.size(); i++) check({tag, "_lo_len"}, 64'(lo_q[i]), 64'd4);
        if (hold > 0) begin
            snap = {59'd0, resp_stable, resp_ones, resp_bit};
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                chal_valid = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                if (!resp_valid || chal_ready || {59'd0, resp_stable, resp_ones, resp_bit} !== snap) bad++;
            end
            chal_valid = 1'b0;
            check({tag, "_backpressure"}, 64'(bad), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_hs_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_hs_ready"}, 64'(chal_ready), 64'd1);
    endtask

    initial begin
        int t1;
        int t2;
        int lat;
        int bad;
        logic [63:0] ch_a;
        logic [63:0] ch_b;
        rst_n      = 1'b0;
        chal_valid = 1'b0;
        chal_data  = 64'd0;
        arb_in     = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_chal_ready", 64'(chal_ready), 64'd1);
        check("rst_chal_out", chal_out, 64'd0);
        check("rst_launch", 64'(launch), 64'd0);
        check("rst_resp", {59'd0, resp_valid, resp_bit, resp_ones}, 64'd0);
        check("rst_stable", 64'(resp_stable), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(chal_ready), 64'd1);
        check("post_rst_launch", 64'(launch), 64'd0);

        do_race("const1", 64'hDEADBEEF_0123_4567, 5'b11111, 0);
        do_race("maj3", {$urandom, $urandom}, 5'b10101, 0);
        do_race("maj2", {$urandom, $urandom}, 5'b10100, 20);
        for (int k = 0; k < 4; k++) do_race("rand", {$urandom, $urandom}, 5'($urandom_range(0, 31)), 0);

        // Back-to-back with chal_valid held high and resp_ready always asserted.
        ch_a = {$urandom, $urandom};
        ch_b = {$urandom, $urandom};
        race_bits = 5'b11111;
        race_idx  = 3'd0;
        chal_data = ch_a;
        chal_valid = 1'b1;
        resp_ready = 1'b1;
        t1 = cyc;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = cyc - t1;
                break;
            end
        end
        check("b2b_lat1", 64'(lat), 64'd50);
        check("b2b_chal_a", chal_out, ch_a);
        race_bits = 5'b00000;
        race_idx  = 3'd0;
        chal_data = ch_b;
        @(posedge clk); #1;
        check("b2b_idle_ready", 64'(chal_ready), 64'd1);
        check("b2b_idle_valid", 64'(resp_valid), 64'd0);
        t2 = cyc;
        @(posedge clk); #1;
        chal_valid = 1'b0;
        check("b2b_accept_gap", 64'(t2 - t1), 64'd51);
        check("b2b_chal_b", chal_out, ch_b);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = cyc - t2;
                break;
            end
        end
        check("b2b_lat2", 64'(lat), 64'd50);
        check("b2b_ones2", 64'(resp_ones), 64'd0);
        check("b2b_stable2", 64'(resp_stable), 64'd1);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("b2b_hs", 64'(resp_valid), 64'd0);

        // Reset during FIRE must drop launch at once and leave no response behind.
        race_bits = 5'b11111;
        race_idx  = 3'd0;
        chal_data = {$urandom, $urandom};
        chal_valid = 1'b1;
        @(posedge clk); #1;
        chal_valid = 1'b0;
        bad = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (launch) begin
                bad = 0;
                break;
            end
        end
        check("mid_fire_reached", 64'(bad), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_launch", 64'(launch), 64'd0);
        check("mid_rst_ready", 64'(chal_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (resp_valid || launch) bad++;
        end
        check("mid_rst_quiet", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
